// File: rtl/lfsr_pkg.sv
// Shared definitions for the XNOR-feedback LFSR generator/checker pair.
//   lfsr_taps : tap mask for a given register length (bit k-1 = tap k)
//   lfsr_fb   : XNOR feedback over SR[len:1], identical at both link ends
//   chk_state_e : checker states
package lfsr_pkg;

    localparam int LFSR_MAX_BITS = 64;

    typedef enum logic {
        FILL  = 1'b0,
        CHECK = 1'b1
    } chk_state_e;

    function automatic logic [LFSR_MAX_BITS-1:0] lfsr_taps(input int num_bits);
        int t [4];
        logic [LFSR_MAX_BITS-1:0] m;
        case (num_bits)
            3:  t = '{3, 2, 0, 0};
            4:  t = '{4, 3, 0, 0};
            5:  t = '{5, 3, 0, 0};
            6:  t = '{6, 5, 0, 0};
            7:  t = '{7, 6, 0, 0};
            8:  t = '{8, 6, 5, 4};
            9:  t = '{9, 5, 0, 0};
            10: t = '{10, 7, 0, 0};
            11: t = '{11, 9, 0, 0};
            12: t = '{12, 6, 4, 1};
            13: t = '{13, 4, 3, 1};
            14: t = '{14, 5, 3, 1};
            15: t = '{15, 14, 0, 0};
            16: t = '{16, 15, 13, 4};
            17: t = '{17, 14, 0, 0};
            18: t = '{18, 11, 0, 0};
            19: t = '{19, 6, 2, 1};
            20: t = '{20, 17, 0, 0};
            21: t = '{21, 19, 0, 0};
            22: t = '{22, 21, 0, 0};
            23: t = '{23, 18, 0, 0};
            24: t = '{24, 23, 22, 17};
            25: t = '{25, 22, 0, 0};
            26: t = '{26, 6, 2, 1};
            27: t = '{27, 5, 2, 1};
            28: t = '{28, 25, 0, 0};
            29: t = '{29, 27, 0, 0};
            30: t = '{30, 6, 4, 1};
            31: t = '{31, 28, 0, 0};
            32: t = '{32, 22, 2, 1};
            64: t = '{64, 63, 61, 60};
            default: t = '{0, 0, 0, 0};
        endcase
        m = '0;
        for (int k = 0; k < 4; k++) begin
            if (t[k] != 0) begin
                m = m | (64'd1 << (t[k] - 1));
            end
        end
        return m;
    endfunction

    // Every tap set has an even number of taps (2 or 4), so the XNOR chain
    // SR[a] ^~ SR[b] ^~ ... reduces to the inverted parity of the tapped bits.
    function automatic logic lfsr_fb(input logic [LFSR_MAX_BITS:1] sr, input int num_bits);
        logic [LFSR_MAX_BITS-1:0] m;
        m = lfsr_taps(num_bits);
        return ~^(sr & m);
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Receive-side checker for the XNOR LFSR pattern generator.
// Fills a local shift register from the incoming stream, then free-runs a
// local LFSR copy and compares every accepted bit against its prediction.
//
// Ports:
//   CLK, RST_N   clock (rising edge), async active-low reset
//   E            bit-valid strobe; DIN sampled only when E=1
//   DIN          received pattern bit (generator's newest bit)
//   CLR          sync clear of ERR_CNT, ERR, ERR_SAT (lock unaffected)
//   RESYNC       sync forced return to FILL (wins over E)
//   LOCK         high while in CHECK
//   ERR          registered one-cycle pulse per mismatch
//   ERR_CNT      saturating mismatch count
//   ERR_SAT      sticky, set when ERR_CNT reaches all-ones
//   LOCKED_ONCE  sticky, set on first FILL->CHECK, cleared only by reset
//
// state | meaning
// FILL  | shifting received bits into SR until NUM_BITS have been taken
// CHECK | flywheel: SR shifts in its own prediction, DIN is compared
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int NUM_BITS    = 32,
    parameter int ERR_W       = 16,
    parameter int LOSS_THRESH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             E,
    input  logic             DIN,
    input  logic             CLR,
    input  logic             RESYNC,
    output logic             LOCK,
    output logic             ERR,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             ERR_SAT,
    output logic             LOCKED_ONCE
);

    localparam int FILL_W = $clog2(NUM_BITS + 1);
    localparam int CONS_W = 4;

    chk_state_e          state, state_nxt;
    logic [NUM_BITS:1]   sr, sr_nxt;
    logic [LFSR_MAX_BITS:1] sr_ext;
    logic [FILL_W-1:0]   fill_cnt, fill_nxt;
    logic [CONS_W-1:0]   cons_cnt, cons_nxt;
    logic                err_nxt;
    logic [ERR_W-1:0]    cnt_nxt;
    logic                sat_nxt;
    logic                once_nxt;
    logic                pred;

    always_comb begin
        sr_ext = '0;
        sr_ext[NUM_BITS:1] = sr;
    end

    assign pred = lfsr_fb(sr_ext, NUM_BITS);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= FILL;
            sr          <= '0;
            fill_cnt    <= '0;
            cons_cnt    <= '0;
            ERR         <= 1'b0;
            ERR_CNT     <= '0;
            ERR_SAT     <= 1'b0;
            LOCKED_ONCE <= 1'b0;
        end else begin
            state       <= state_nxt;
            sr          <= sr_nxt;
            fill_cnt    <= fill_nxt;
            cons_cnt    <= cons_nxt;
            ERR         <= err_nxt;
            ERR_CNT     <= cnt_nxt;
            ERR_SAT     <= sat_nxt;
            LOCKED_ONCE <= once_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        fill_nxt  = fill_cnt;
        cons_nxt  = cons_cnt;
        err_nxt   = 1'b0;
        cnt_nxt   = ERR_CNT;
        sat_nxt   = ERR_SAT;
        once_nxt  = LOCKED_ONCE;

        if (RESYNC) begin
            state_nxt = FILL;
            fill_nxt  = '0;
            cons_nxt  = '0;
        end else if (E) begin
            case (state)
                FILL: begin
                    sr_nxt = {sr[NUM_BITS-1:1], DIN};
                    if (fill_cnt == FILL_W'(NUM_BITS - 1)) begin
                        state_nxt = CHECK;
                        fill_nxt  = '0;
                        once_nxt  = 1'b1;
                    end else begin
                        fill_nxt = fill_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    // Flywheel: a corrupted DIN never enters SR, so one bad
                    // bit costs exactly one error.
                    sr_nxt = {sr[NUM_BITS-1:1], pred};
                    if (DIN != pred) begin
                        err_nxt = 1'b1;
                        if (ERR_CNT != '1) begin
                            cnt_nxt = ERR_CNT + 1'b1;
                        end
                        if (cnt_nxt == '1) begin
                            sat_nxt = 1'b1;
                        end
                        if (cons_cnt == CONS_W'(LOSS_THRESH - 1)) begin
                            state_nxt = FILL;
                            fill_nxt  = '0;
                            cons_nxt  = '0;
                        end else begin
                            cons_nxt = cons_cnt + 1'b1;
                        end
                    end else begin
                        cons_nxt = '0;
                    end
                end
                default: state_nxt = FILL;
            endcase
        end

        if (CLR) begin
            cnt_nxt = '0;
            err_nxt = 1'b0;
            sat_nxt = 1'b0;
        end
    end

    assign LOCK = (state == CHECK);

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side counterpart of the team's XNOR-feedback LFSR pattern generator.
- Takes the generated bit stream one bit per enabled clock and self-synchronises by filling a local shift register from the incoming bits.
- Then free-runs a local copy of the LFSR and compares every received bit against the prediction, reporting lock, per-bit errors and a saturating error count.
- Sits at the far end of a link or loopback under test (BIST of serial paths, UART/SPI loopback on the MCS-51 platform).

Parameters:
NUM_BITS, 32, LFSR length; legal values 3..32 and 64, with the same tap set as the generator.
ERR_W, 16, width of the error counter.
LOSS_THRESH, 4, consecutive mismatches that drop lock and force a resync; legal range 1..15.

Ports:
CLK  input  1  system clock, rising edge.
RST_N  input  1  asynchronous active-low reset.
E  input  1  bit-valid strobe; DIN is sampled only when E=1.
DIN  input  1  received pattern bit, equal to the generator's newest bit (generator LFSData[0]).
CLR  input  1  synchronous clear of ERR_CNT, ERR and the saturation flag; does not affect lock.
RESYNC  input  1  synchronous forced return to FILL.
LOCK  output  1  high while in CHECK state.
ERR  output  1  one-cycle pulse, registered, on a mismatch in CHECK.
ERR_CNT  output  ERR_W  saturating count of mismatches since reset or CLR.
ERR_SAT  output  1  sticky; set when ERR_CNT reaches all-ones.
LOCKED_ONCE  output  1  sticky; set on the first FILL->CHECK transition and cleared only by reset.

Behaviour:
- Reset (RST_N=0, asynchronous): state=FILL, SR=0, fill count=0, consecutive-error count=0. All outputs 0.
- Local register SR[NUM_BITS:1] uses the generator's ordering:
  - On an accepted bit b: SR <= {SR[NUM_BITS-1:1], b}.
  - Prediction P = XNOR reduction of the generator's taps for NUM_BITS applied to SR, e.g. 8: SR[8]^~SR[6]^~SR[5]^~SR[4]; 32: taps 32,22,2,1.
- FILL state:
  - Each E=1 shifts DIN into SR and increments the fill count.
  - On the E=1 cycle that makes fill count = NUM_BITS: go to CHECK, and LOCK=1 from the next cycle.
  - No errors are counted in FILL.
- CHECK state, on each E=1:
  - mismatch = DIN != P.
  - SR shifts in P (flywheel), not DIN, so a single corrupted bit costs exactly one error.
  - On mismatch: ERR=1 next cycle; ERR_CNT+1, saturating at 2^ERR_W-1, where ERR_SAT is set; consecutive-error count +1.
  - On match: consecutive-error count=0.
  - When consecutive-error count reaches LOSS_THRESH (on the accepted bit): go to FILL, clear fill count and consecutive-error count. LOCK=0 next cycle. The bit that triggers the loss is counted as an error.
- E=0: no state change; ERR deasserts (it is a pulse only).
- RESYNC=1: go to FILL, clear fill count and consecutive-error count, regardless of E. ERR_CNT is untouched.
  - RESYNC and E together: RESYNC wins and DIN is discarded.
- CLR and a mismatch in the same cycle: CLR wins, so ERR_CNT=0 and ERR=0.
- All-ones SR is the XNOR lockup state. The checker tracks it normally (predicts 1s); it is not an error.
- Latency: ERR, LOCK and ERR_CNT are all updated at the clock edge that samples the bit, so they are visible one cycle after E.

Decomposition:
- Shared package lfsr_pkg holds:
  - function lfsr_fb(sr, NUM_BITS) implementing the tap table, reused by the generator so both ends stay identical;
  - a checker state enum {FILL, CHECK}.
- No sub-module is needed beyond the package function. The saturating counter stays inline.

Test Plan:
- NUM_BITS=8, generator seeded 0x00, E=1 every cycle, DIN=generator LSB → LOCK rises one cycle after the 8th accepted bit; ERR_CNT=0 after 1000 bits; LOCKED_ONCE=1.
- Locked, then invert one DIN bit → exactly one ERR pulse; ERR_CNT=1; LOCK stays 1.
- Locked, LOSS_THRESH=4, invert 4 consecutive bits → ERR_CNT=4 and LOCK=0 after the 4th; relock after 8 further clean bits; ERR_CNT stays 4.
- ERR_W=4, continuous inverted stream with LOSS_THRESH=15 → ERR_CNT sticks at 15; ERR_SAT=1; CLR → ERR_CNT=0 and ERR_SAT=0.
- E toggled 1-of-3 cycles → same LOCK timing counted in accepted bits; no errors.
- Assert RST_N low mid-CHECK, asynchronously between edges → outputs 0 immediately; after release, LOCK needs 8 fresh bits.
